// File: rtl/key_event_sequencer.sv
// Debounced 4x4 keypad event sequencer with a two-digit multiplexed display.
// Accepts one key per full press/release cycle and shows the last two accepted digits.
module key_event_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4096,
    parameter logic [15:0] MUX_CYCLES      = 16'd1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic [3:0] rows,
    input  logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic [1:0] seg_sel,
    output logic [3:0] seg_digit
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] DEB_LAST = (DEBOUNCE_CYCLES <= 16'd1) ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;
    localparam logic [CNT_W-1:0] MUX_LAST = (MUX_CYCLES <= 16'd1) ? 16'd0 : MUX_CYCLES - 16'd1;
    // Nibble i holds the code for row i/4, column i%4.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [3:0]       cand_q, cand_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [3:0]       digit_new_q, digit_new_d;
    logic [3:0]       digit_old_q, digit_old_d;
    logic [1:0]       seg_sel_q, seg_sel_d;
    logic [3:0]       seg_digit_q, seg_digit_d;

    logic [1:0]       row_idx_c, col_idx_c;
    logic [3:0]       code_c;
    logic             valid_c, active_c, accept_c;
    logic [3:0]       accept_code_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Combinational keypad decode.
    always_comb begin
        row_idx_c = 2'd0;
        col_idx_c = 2'd0;
        case (rows)
            4'b1101: row_idx_c = 2'd1;
            4'b1011: row_idx_c = 2'd2;
            4'b0111: row_idx_c = 2'd3;
            default: row_idx_c = 2'd0;
        endcase
        case (cols)
            4'b1101: col_idx_c = 2'd1;
            4'b1011: col_idx_c = 2'd2;
            4'b0111: col_idx_c = 2'd3;
            default: col_idx_c = 2'd0;
        endcase
        code_c   = KEY_MAP[{row_idx_c, col_idx_c, 2'b00} +: 4];
        valid_c  = press && $onehot(~rows) && $onehot(~cols);
        // Multi-key (ghost) contacts still mean a key is down, so they hold off release.
        active_c = press && (rows != 4'hF) && (cols != 4'hF);
    end

    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        accept_c      = 1'b0;
        accept_code_c = cand_q;
        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    cand_d = code_c;
                    cnt_d  = '0;
                    if (DEB_LAST == 16'd0) begin
                        accept_c      = 1'b1;
                        accept_code_c = code_c;
                        state_d       = HELD;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (valid_c && (code_c == cand_q)) begin
                    if (cnt_inc_c >= DEB_LAST) begin
                        accept_c = 1'b1;
                        cnt_d    = '0;
                        state_d  = HELD;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!active_c) begin
                    cnt_d   = '0;
                    state_d = (DEB_LAST == 16'd0) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (active_c) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_inc_c >= DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        key_valid_d = accept_c;
        key_code_d  = accept_c ? accept_code_c : key_code_q;
        digit_new_d = accept_c ? accept_code_c : digit_new_q;
        digit_old_d = accept_c ? digit_new_q   : digit_old_q;

        // Free-running display mux; seg_digit follows next-cycle values so the pair stays aligned.
        div_d       = (div_q >= MUX_LAST) ? '0 : div_q + 16'd1;
        seg_sel_d   = (div_q >= MUX_LAST) ? ~seg_sel_q : seg_sel_q;
        seg_digit_d = (seg_sel_d == 2'b10) ? digit_new_d : digit_old_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            digit_new_q <= '0;
            digit_old_q <= '0;
            seg_sel_q   <= 2'b10;
            seg_digit_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            seg_sel_q   <= seg_sel_d;
            seg_digit_q <= seg_digit_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign seg_sel   = seg_sel_q;
    assign seg_digit = seg_digit_q;
endmodule

// File: tb/tb_key_event_sequencer.sv
// Self-checking bench for key_event_sequencer: accept events are queued as
// expected when keys are driven and matched against pulses seen on key_valid.
module tb_key_event_sequencer;
    logic       clk;
    logic       reset;
    logic       press;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic [1:0] seg_sel;
    logic [3:0] seg_digit;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] dnew;
        logic [3:0] dold;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [3:0] exp_new;
    logic [3:0] exp_old;
    int         errors;
    int         checks;

    key_event_sequencer #(
        .DEBOUNCE_CYCLES(16'd4),
        .MUX_CYCLES     (16'd3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .press    (press),
        .rows     (rows),
        .cols     (cols),
        .key_valid(key_valid),
        .key_code (key_code),
        .digit_new(digit_new),
        .digit_old(digit_old),
        .seg_sel  (seg_sel),
        .seg_digit(seg_digit)
    );

    always #5 clk = ~clk;

    // Advance n cycles, sampling 1 time unit after each rising edge and logging pulses.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (key_valid === 1'b1) obs_q.push_back('{key_code, digit_new, digit_old});
        end
    endtask

    task automatic drive_key(input int r, input int c);
        press = 1'b1;
        rows  = ~(4'b0001 << r);
        cols  = ~(4'b0001 << c);
    endtask

    task automatic no_key;
        press = 1'b0;
        rows  = 4'hF;
        cols  = 4'hF;
    endtask

    // Reference model of the digit history on each accept.
    task automatic expect_accept(input logic [3:0] code);
        exp_q.push_back('{code, code, exp_new});
        exp_old = exp_new;
        exp_new = code;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        no_key();
        cycle(2);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h want 0", key_code); end
        checks++; if (digit_new !== 4'h0) begin errors++; $display("FAIL reset_digit_new: got %h want 0", digit_new); end
        checks++; if (digit_old !== 4'h0) begin errors++; $display("FAIL reset_digit_old: got %h want 0", digit_old); end
        checks++; if (seg_sel !== 2'b10) begin errors++; $display("FAIL reset_seg_sel: got %b want 10", seg_sel); end
        checks++; if (seg_digit !== 4'h0) begin errors++; $display("FAIL reset_seg_digit: got %h want 0", seg_digit); end
        reset = 1'b1;
        obs_q.delete();
    endtask

    task automatic test_accept;
        ev_t e, o;
        drive_key(1, 2);
        expect_accept(4'h6);
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            checks++;
            if (key_valid !== (i == 3)) begin
                errors++; $display("FAIL accept_timing cycle %0d: got key_valid=%b want %b", i, key_valid, (i == 3));
            end
        end
        no_key();
        cycle(8);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL accept_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL accept_event: got code/new/old=%h/%h/%h want %h/%h/%h", o.code, o.dnew, o.dold, e.code, e.dnew, e.dold); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_short_press;
        drive_key(0, 2);
        cycle(2);
        no_key();
        cycle(8);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL short_press_pulses: got %0d want 0", obs_q.size()); end
        checks++; if (digit_new !== exp_new || digit_old !== exp_old) begin
            errors++; $display("FAIL short_press_digits: got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old);
        end
        obs_q.delete();
    endtask

    task automatic test_bounce;
        ev_t e, o;
        drive_key(1, 1);
        expect_accept(4'h5);
        cycle(6);
        no_key();     cycle(2);
        drive_key(1, 1); cycle(2);
        no_key();     cycle(6);
        drive_key(2, 2);
        expect_accept(4'h9);
        cycle(6);
        no_key();
        cycle(8);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL bounce_count: got %0d want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bounce_event: got code/new/old=%h/%h/%h want %h/%h/%h", o.code, o.dnew, o.dold, e.code, e.dnew, e.dold); end
        end
        checks++; if (digit_new !== 4'h9 || digit_old !== 4'h5) begin
            errors++; $display("FAIL bounce_digits: got %h/%h want 9/5", digit_new, digit_old);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_multikey;
        ev_t e, o;
        drive_key(0, 0);
        expect_accept(4'h1);
        cycle(6);
        cols = 4'b0110;
        cycle(5);
        cols = 4'b1110;
        cycle(3);
        checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL multikey_code: got %h want 1", key_code); end
        no_key();
        cycle(8);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL multikey_count: got %0d want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL multikey_event: got code/new/old=%h/%h/%h want %h/%h/%h", o.code, o.dnew, o.dold, e.code, e.dnew, e.dold); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mux;
        logic [1:0] prev, exp_sel;
        logic [3:0] want;
        int         since;
        bit         locked;
        drive_key(1, 0); expect_accept(4'h4); cycle(6);
        no_key(); cycle(8);
        drive_key(0, 3); expect_accept(4'hA); cycle(6);
        no_key(); cycle(8);
        checks++; if (obs_q.size() != 2 || obs_q[1] !== exp_q[1]) begin
            errors++; $display("FAIL mux_setup: got %0d pulses last=%h want 2 last=%h", obs_q.size(), obs_q[obs_q.size()-1], exp_q[1]);
        end
        exp_q.delete(); obs_q.delete();
        prev = seg_sel; exp_sel = seg_sel; since = 0; locked = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            want = (seg_sel == 2'b10) ? 4'hA : 4'h4;
            checks++;
            if (!(seg_sel == 2'b10 || seg_sel == 2'b01) || seg_digit !== want) begin
                errors++; $display("FAIL mux_pairing cycle %0d: got sel=%b digit=%h want digit=%h", i, seg_sel, seg_digit, want);
            end
            if (locked) begin
                since++;
                if (since == 3) begin exp_sel = ~exp_sel; since = 0; end
                checks++;
                if (seg_sel !== exp_sel) begin errors++; $display("FAIL mux_period cycle %0d: got %b want %b", i, seg_sel, exp_sel); end
            end else if (seg_sel !== prev) begin
                locked = 1; exp_sel = seg_sel; since = 0;
            end
            prev = seg_sel;
        end
        checks++; if (!locked) begin errors++; $display("FAIL mux_toggle: got no seg_sel change want toggling"); end
    endtask

    task automatic test_reset_mid_confirm;
        ev_t e, o;
        drive_key(2, 0);
        cycle(2);
        reset = 1'b0;
        cycle(1);
        checks++; if (key_valid !== 1'b0 || key_code !== 4'h0 || digit_new !== 4'h0 || digit_old !== 4'h0) begin
            errors++; $display("FAIL midreset_outputs: got kv=%b code=%h new=%h old=%h want 0/0/0/0", key_valid, key_code, digit_new, digit_old);
        end
        checks++; if (seg_sel !== 2'b10 || seg_digit !== 4'h0) begin
            errors++; $display("FAIL midreset_display: got sel=%b digit=%h want 10/0", seg_sel, seg_digit);
        end
        reset = 1'b1;
        exp_new = 4'h0; exp_old = 4'h0;
        obs_q.delete();
        expect_accept(4'h7);
        for (int i = 0; i < 6; i++) begin
            cycle(1);
            checks++;
            if (key_valid !== (i == 3)) begin
                errors++; $display("FAIL midreset_debounce cycle %0d: got key_valid=%b want %b", i, key_valid, (i == 3));
            end
        end
        no_key();
        cycle(8);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL midreset_event: got code/new/old=%h/%h/%h want %h/%h/%h", o.code, o.dnew, o.dold, e.code, e.dnew, e.dold); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        errors = 0;
        checks = 0;
        exp_new = 4'h0;
        exp_old = 4'h0;
        no_key();
        test_reset();
        test_accept();
        test_short_press();
        test_bounce();
        test_multikey();
        test_mux();
        test_reset_mid_confirm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
